// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bundle for the seven-segment scan controller.
// Load handshake, decoder loop-back and the segment/anode drive.
interface ssd_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        ready;
  logic [3:0]  digit_code;
  logic [7:0]  seg_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output value, dp, load, seg_in,
    input  ready, digit_code, seg, an, frame_done
  );

  modport slave (
    input  value, dp, load, seg_in,
    output ready, digit_code, seg, an, frame_done
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// 4-digit common-anode scan controller with frame-aligned double buffer.
// Optional leading-zero blanking when SSD_LZB_EN is defined.
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000
) (
  input logic           clk,
  input logic           rst,
  ssd_scan_ctrl_if.slave bus
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW:0] GUARD_W = (CW+1)'(GUARD);
  localparam logic [3:0] AN_RST =
    (GUARD == 0) ? 4'b1110 : 4'b1111;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   sh_val, act_val, act_val_nxt;
  logic [3:0]    sh_dp, act_dp, act_dp_nxt;
  logic          pending, pending_nxt;
  logic [3:0]    code_q, code_nxt;
  logic [3:0]    an_q, an_nxt;
  logic          fd_q;
  logic          wrap, boundary, take;
  logic [15:0]   sel_sh;
  logic          blank, dp_on;
  logic [7:0]    seg_c;

  // Next scan position, buffer transfer and next-cycle controls
  always_comb begin
    wrap        = (cnt == CNT_LAST);
    boundary    = wrap && (idx == 2'd3);
    take        = bus.load && !pending;
    cnt_nxt     = wrap ? '0 : cnt + 1'b1;
    idx_nxt     = wrap ? idx + 2'd1 : idx;
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    pending_nxt = pending;
    if (boundary && pending) begin
      act_val_nxt = sh_val;
      act_dp_nxt  = sh_dp;
      pending_nxt = 1'b0;
    end else if (take) begin
      pending_nxt = 1'b1;
    end
    sel_sh   = act_val_nxt >> {idx_nxt, 2'b00};
    code_nxt = sel_sh[3:0];
    if ({1'b0, cnt_nxt} < GUARD_W)
      an_nxt = 4'b1111;
    else
      an_nxt = ~(4'b0001 << idx_nxt);
  end

  // State and registered display controls
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      sh_val  <= 16'h0000;
      sh_dp   <= 4'h0;
      act_val <= 16'h0000;
      act_dp  <= 4'h0;
      pending <= 1'b0;
      code_q  <= 4'h0;
      an_q    <= AN_RST;
      fd_q    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
      pending <= pending_nxt;
      code_q  <= code_nxt;
      an_q    <= an_nxt;
      fd_q    <= boundary;
      if (take) begin
        sh_val <= bus.value;
        sh_dp  <= bus.dp;
      end
    end
  end

  // Blanking decision and segment drive for the digit on screen
  always_comb begin
    blank = 1'b0;
`ifdef SSD_LZB_EN
    case (idx)
      2'd3: blank = (act_val[15:12] == 4'h0);
      2'd2: blank = (act_val[15:8] == 8'h00);
      2'd1: blank = (act_val[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    dp_on = act_dp[idx];
    if (an_q == 4'b1111)
      seg_c = 8'hFF;
    else if (blank)
      seg_c = {7'h7F, ~dp_on};
    else
      seg_c = {bus.seg_in[7:1], bus.seg_in[0] & ~dp_on};
  end

  assign bus.ready      = ~pending;
  assign bus.digit_code = code_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
  assign bus.seg        = seg_c;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl, REFRESH_DIV=8, GUARD=2.
// Build with +define+SSD_LZB_EN to cover leading-zero blanking.
module tb_ssd_scan_ctrl;
  localparam int RD = 8;
  localparam int GD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if bus();

  ssd_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [6:0] hex7(input logic [3:0] c);
    case (c)
      4'h0: return 7'h7E;
      4'h1: return 7'h30;
      4'h2: return 7'h6D;
      4'h3: return 7'h79;
      4'h4: return 7'h33;
      4'h5: return 7'h5B;
      4'h6: return 7'h5F;
      4'h7: return 7'h70;
      4'h8: return 7'h7F;
      4'h9: return 7'h7B;
      4'hA: return 7'h77;
      4'hB: return 7'h1F;
      4'hC: return 7'h4E;
      4'hD: return 7'h3D;
      4'hE: return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

  assign bus.seg_in = {~hex7(bus.digit_code), 1'b1};

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic [7:0] seg;
  } slot_t;

  slot_t sb[$];
  int total = 0;
  int bad = 0;
  int k = 0;
  logic [15:0] m_val, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend, fd_exp;

  function automatic logic [7:0] exp_seg(
    input logic [15:0] v, input logic [3:0] d, input int n);
    logic [15:0] s;
    logic        bl;
    s  = v >> (4 * n);
    bl = 1'b0;
`ifdef SSD_LZB_EN
    bl = (n > 0) && (s == 16'h0000);
`endif
    if (bl) return {7'h7F, ~d[n]};
    return {~hex7(s[3:0]), ~d[n]};
  endfunction

  task automatic push_frame(input logic [15:0] v,
                            input logic [3:0] d);
    for (int n = 0; n < 4; n++) begin
      slot_t e;
      logic [15:0] s;
      logic [3:0] a;
      s = v >> (4 * n);
      a = 4'b0001 << n;
      e.an   = ~a;
      e.code = s[3:0];
      e.seg  = exp_seg(v, d, n);
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      k = 0;
      m_val = '0; m_dp = '0;
      m_sh = '0; m_shdp = '0;
      m_pend = 1'b0; fd_exp = 1'b0;
    end else begin
      fd_exp = (k % 32 == 31);
      if (fd_exp && m_pend) begin
        m_val = m_sh; m_dp = m_shdp; m_pend = 1'b0;
      end else if (bus.load && !m_pend) begin
        m_sh = bus.value; m_shdp = bus.dp; m_pend = 1'b1;
      end
      k++;
    end
    @(negedge clk);
  endtask

  task automatic step_to(input int ph);
    for (int i = 0; i < 64; i++) begin
      step();
      if (k % 32 == ph) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.load = 1'b0;
    bus.value = '0; bus.dp = '0;
    step(); step();
    total += 5;
    if (bus.an !== 4'b1111) begin
      bad++; $display("FAIL rst_an got=%b need=1111", bus.an);
    end
    if (bus.seg !== 8'hFF) begin
      bad++; $display("FAIL rst_seg got=%h need=ff", bus.seg);
    end
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b need=1", bus.ready);
    end
    if (bus.frame_done !== 1'b0) begin
      bad++; $display("FAIL rst_fd got=%b need=0", bus.frame_done);
    end
    if (bus.digit_code !== 4'h0) begin
      bad++; $display("FAIL rst_code got=%h need=0", bus.digit_code);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      total++;
      if (bus.digit_code !== 4'h0) begin
        bad++;
        $display("FAIL idle_code k=%0d got=%h need=0",
                 k, bus.digit_code);
      end
    end
  endtask

  task automatic test_load();
    step_to(9);
    bus.value = 16'h12AB; bus.dp = 4'b0100; bus.load = 1'b1;
    push_frame(16'h12AB, 4'b0100);
    step();
    bus.load = 1'b0;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL load_ready got=%b need=0", bus.ready);
    end
    step_to(0);
    total += 2;
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL bnd_ready got=%b need=1", bus.ready);
    end
    if (bus.frame_done !== 1'b1) begin
      bad++; $display("FAIL bnd_fd got=%b need=1", bus.frame_done);
    end
    for (int i = 0; i < 31; i++) begin
      step();
      if (k % 8 == 2) begin
        slot_t e;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL load_sb empty k=%0d", k);
        end else begin
          e = sb.pop_front();
          if (bus.an !== e.an || bus.digit_code !== e.code ||
              bus.seg !== e.seg) begin
            bad++;
            $display("FAIL load_slot k=%0d got=%b/%h/%h need=%b/%h/%h",
                     k, bus.an, bus.digit_code, bus.seg,
                     e.an, e.code, e.seg);
          end
        end
      end
      if (k % 32 == 18) begin
        total++;
        if (bus.seg[0] !== 1'b0) begin
          bad++; $display("FAIL dp2 got=%b need=0", bus.seg[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_to(20);
    bus.value = 16'h3456; bus.dp = 4'b0001; bus.load = 1'b1;
    push_frame(16'h3456, 4'b0001);
    push_frame(16'h789A, 4'b1000);
    step();
    bus.value = 16'h789A; bus.dp = 4'b1000;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL b2b_ready got=%b need=0", bus.ready);
    end
    step_to(0);
    total += 2;
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL b2b_rise got=%b need=1", bus.ready);
    end
    if (bus.digit_code !== 4'h6) begin
      bad++; $display("FAIL b2b_code got=%h need=6", bus.digit_code);
    end
    step();
    bus.load = 1'b0;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL b2b_held got=%b need=0", bus.ready);
    end
    for (int i = 0; i < 62; i++) begin
      step();
      if (k % 8 == 2) begin
        slot_t e;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_sb empty k=%0d", k);
        end else begin
          e = sb.pop_front();
          if (bus.an !== e.an || bus.digit_code !== e.code ||
              bus.seg !== e.seg) begin
            bad++;
            $display("FAIL b2b_slot k=%0d got=%b/%h/%h need=%b/%h/%h",
                     k, bus.an, bus.digit_code, bus.seg,
                     e.an, e.code, e.seg);
          end
        end
      end
    end
  endtask

  task automatic test_guard();
    logic [3:0] prev, ea, oh;
    int ons;
    prev = 4'b1111; ons = 0;
    step_to(31);
    for (int i = 0; i < 32; i++) begin
      step();
      oh = 4'b0001 << ((k / 8) % 4);
      ea = (k % 8 < GD) ? 4'b1111 : ~oh;
      total += 2;
      if (bus.an !== ea) begin
        bad++;
        $display("FAIL guard_an k=%0d got=%b need=%b", k, bus.an, ea);
      end
      if (bus.frame_done !== fd_exp) begin
        bad++;
        $display("FAIL guard_fd k=%0d got=%b need=%b",
                 k, bus.frame_done, fd_exp);
      end
      if (prev == 4'b1111 && bus.an != 4'b1111) ons++;
      prev = bus.an;
    end
    total++;
    if (ons != 4) begin
      bad++; $display("FAIL guard_count got=%0d need=4", ons);
    end
  endtask

  task automatic test_reset_mid();
    step_to(17);
    bus.value = 16'hFFFF; bus.dp = 4'hF; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++; $display("FAIL mid_pend got=%b need=0", bus.ready);
    end
    step_to(20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total += 4;
    if (bus.an !== 4'b1111) begin
      bad++; $display("FAIL mid_an got=%b need=1111", bus.an);
    end
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got=%b need=1", bus.ready);
    end
    if (bus.digit_code !== 4'h0) begin
      bad++; $display("FAIL mid_code got=%h need=0", bus.digit_code);
    end
    if (bus.seg !== 8'hFF) begin
      bad++; $display("FAIL mid_seg got=%h need=ff", bus.seg);
    end
    for (int i = 0; i < 64; i++) begin
      step();
      if (k == 2) begin
        total++;
        if (bus.an !== 4'b1110) begin
          bad++; $display("FAIL mid_d0 got=%b need=1110", bus.an);
        end
      end
      if (k % 8 == 2) begin
        total++;
        if (bus.digit_code !== 4'h0) begin
          bad++;
          $display("FAIL mid_act k=%0d got=%h need=0",
                   k, bus.digit_code);
        end
      end
    end
    total++;
    if (bus.ready !== 1'b1) begin
      bad++; $display("FAIL mid_shadow got=%b need=1", bus.ready);
    end
  endtask

  task automatic test_lzb();
    step_to(5);
    bus.value = 16'h0050; bus.dp = 4'b1000; bus.load = 1'b1;
    push_frame(16'h0050, 4'b1000);
    step();
    bus.load = 1'b0;
    step_to(0);
    for (int i = 0; i < 31; i++) begin
      step();
      if (k % 8 == 2) begin
        slot_t e;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL lzb_sb empty k=%0d", k);
        end else begin
          e = sb.pop_front();
          if (bus.an !== e.an || bus.digit_code !== e.code ||
              bus.seg !== e.seg) begin
            bad++;
            $display("FAIL lzb_slot k=%0d got=%b/%h/%h need=%b/%h/%h",
                     k, bus.an, bus.digit_code, bus.seg,
                     e.an, e.code, e.seg);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_left got=%0d need=0", sb.size());
    end
  endtask

  initial begin
    bus.load = 1'b0;
    bus.value = '0;
    bus.dp = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_guard();
    test_reset_mid();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
